// File: rtl/icb_arb_5to1_rr_if.sv
`default_nettype none
// ============================================================================
// Module   : icb_arb_5to1_rr_if
// Purpose  : Bundles the requester valid lines, the snooped master-side ICB
//            handshakes and the arbiter status outputs of icb_arb_5to1_rr.
// Ports    : req_vld      - raw cmd.valid of each requester (before the mux)
//            m_cmd_*      - master-side command channel (mux output)
//            m_w_*        - master-side write-data handshake
//            m_rsp_*      - master-side response handshake
//            sel          - mux select (0..4 granted, 7 none)
//            busy         - a grant is being held
//            timeout_err  - watchdog released a stuck grant (1-cycle pulse)
// Modports : slave  - the arbiter (consumes handshakes, drives sel/status)
//            master - the environment (drives handshakes, observes sel/status)
// Revision : 1.0 - initial release
// ============================================================================
interface icb_arb_5to1_rr_if #(
  parameter int N_REQ = 5,
  parameter int LEN_W = 8
);
  logic [N_REQ-1:0] req_vld;
  logic             m_cmd_valid;
  logic             m_cmd_ready;
  logic             m_cmd_read;
  logic [LEN_W-1:0] m_cmd_len;
  logic             m_w_valid;
  logic             m_w_ready;
  logic             m_rsp_valid;
  logic             m_rsp_ready;
  logic [2:0]       sel;
  logic             busy;
  logic             timeout_err;

  modport slave (
    input  req_vld, m_cmd_valid, m_cmd_ready, m_cmd_read, m_cmd_len,
           m_w_valid, m_w_ready, m_rsp_valid, m_rsp_ready,
    output sel, busy, timeout_err
  );

  modport master (
    output req_vld, m_cmd_valid, m_cmd_ready, m_cmd_read, m_cmd_len,
           m_w_valid, m_w_ready, m_rsp_valid, m_rsp_ready,
    input  sel, busy, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/icb_arb_5to1_rr.sv
`default_nettype none
// ============================================================================
// Module   : icb_arb_5to1_rr
// Purpose  : Round-robin arbiter and transaction tracker producing the select
//            for the 5:1 ICB requester mux. A grant is held until the command,
//            all write beats and all responses of the transaction complete,
//            or until the watchdog expires.
// Ports    : clk  - clock
//            rst  - synchronous reset, active-high
//            bus  - icb_arb_5to1_rr_if.slave (handshake snoop + sel/status)
// Revision : 1.0 - initial release
// ============================================================================
module icb_arb_5to1_rr #(
  parameter int N_REQ       = 5,     // sel encoding assumes exactly 5
  parameter int LEN_W       = 8,     // must match the interface LEN_W
  parameter int TIMEOUT_CYC = 1024   // 0 disables the watchdog
) (
  input  wire logic        clk,
  input  wire logic        rst,
  icb_arb_5to1_rr_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CMD  = 3'd1,
    ST_WDAT = 3'd2,
    ST_WRSP = 3'd3,
    ST_RRSP = 3'd4
  } state_t;

  localparam logic [2:0]       c_sel_none = 3'd7;
  localparam logic [2:0]       c_last_rst = 3'(N_REQ - 1);
  localparam int               CYC_W      = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CYC_W-1:0] c_cyc_max  = CYC_W'(TIMEOUT_CYC - 1);

  state_t           r_state, w_state_n;
  logic [2:0]       r_sel, w_sel_n;
  logic [2:0]       r_last, w_last_n;
  logic [LEN_W:0]   r_beats, w_beats_n;
  logic [LEN_W:0]   r_cnt, w_cnt_n;   // write beats in WDAT, responses in RRSP
  logic [CYC_W-1:0] r_cyc, w_cyc_n;

  logic             w_cmd_hs, w_w_hs, w_r_hs;
  logic             w_req_granted;
  logic [2:0]       w_winner;
  logic             w_any_req;
  logic             w_done;
  logic             w_timeout;
  logic [LEN_W:0]   w_len_beats;
  logic [LEN_W:0]   w_cnt_inc;

  assign w_cmd_hs    = bus.m_cmd_valid & bus.m_cmd_ready;
  assign w_w_hs      = bus.m_w_valid   & bus.m_w_ready;
  assign w_r_hs      = bus.m_rsp_valid & bus.m_rsp_ready;
  assign w_any_req   = |bus.req_vld;
  assign w_len_beats = {1'b0, bus.m_cmd_len} + {{LEN_W{1'b0}}, 1'b1};
  assign w_cnt_inc   = r_cnt + {{LEN_W{1'b0}}, 1'b1};

  // Valid line of the currently granted requester (0 when nothing granted).
  always_comb begin
    w_req_granted = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_sel == 3'(i)) w_req_granted = bus.req_vld[i];
    end
  end

  // Round-robin pick: first set bit starting just after the last winner.
  always_comb begin
    logic found;
    found    = 1'b0;
    w_winner = c_sel_none;
    for (int k = 1; k <= N_REQ; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!found && (i == (int'(r_last) + k) % N_REQ) && bus.req_vld[i]) begin
          w_winner = 3'(i);
          found    = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sel   <= c_sel_none;
      r_last  <= c_last_rst;
      r_beats <= '0;
      r_cnt   <= '0;
      r_cyc   <= '0;
    end else begin
      r_state <= w_state_n;
      r_sel   <= w_sel_n;
      r_last  <= w_last_n;
      r_beats <= w_beats_n;
      r_cnt   <= w_cnt_n;
      r_cyc   <= w_cyc_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_sel_n   = r_sel;
    w_last_n  = r_last;
    w_beats_n = r_beats;
    w_cnt_n   = r_cnt;
    w_cyc_n   = r_cyc + CYC_W'(1);
    w_done    = 1'b0;
    w_timeout = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // Handshakes seen here belong to nobody and are dropped.
        w_cyc_n = '0;
        if (w_any_req) begin
          w_sel_n   = w_winner;
          w_state_n = ST_CMD;
        end
      end
      ST_CMD: begin
        if (w_cmd_hs) begin
          w_beats_n = w_len_beats;
          if (bus.m_cmd_read) begin
            w_cnt_n   = '0;
            w_state_n = ST_RRSP;
          end else if (w_w_hs) begin
            // First write beat may ride along with the command.
            w_cnt_n   = {{LEN_W{1'b0}}, 1'b1};
            w_state_n = (w_len_beats == {{LEN_W{1'b0}}, 1'b1}) ? ST_WRSP : ST_WDAT;
          end else begin
            w_cnt_n   = '0;
            w_state_n = ST_WDAT;
          end
        end else if (!w_req_granted) begin
          // Requester withdrew before the command went out: release without
          // advancing the round-robin pointer.
          w_state_n = ST_IDLE;
          w_sel_n   = c_sel_none;
        end
      end
      ST_WDAT: begin
        if (w_w_hs) begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc == r_beats) w_state_n = ST_WRSP;
        end
      end
      ST_WRSP: begin
        if (w_r_hs) w_done = 1'b1;
      end
      ST_RRSP: begin
        if (w_r_hs) begin
          w_cnt_n = w_cnt_inc;
          if (w_cnt_inc == r_beats) w_done = 1'b1;
        end
      end
      default: begin
        w_state_n = ST_IDLE;
        w_sel_n   = c_sel_none;
      end
    endcase

    // Completion takes precedence over the watchdog in the same cycle.
    if (w_done) begin
      w_state_n = ST_IDLE;
      w_sel_n   = c_sel_none;
      w_last_n  = r_sel;
    end else if ((TIMEOUT_CYC != 0) && (r_state != ST_IDLE) && (r_cyc == c_cyc_max)) begin
      w_timeout = 1'b1;
      w_state_n = ST_IDLE;
      w_sel_n   = c_sel_none;
      w_last_n  = r_sel;
    end
  end

  assign bus.sel         = r_sel;
  assign bus.busy        = (r_state != ST_IDLE);
  // A reset cycle abandons the transaction silently.
  assign bus.timeout_err = w_timeout & ~rst;

endmodule
`default_nettype wire

// File: doc/icb_arb_5to1_rr.md
Name: icb_arb_5to1_rr

Overview:
- Round-robin arbiter and transaction tracker that generates `sel` for the 5:1 ICB requester multiplexer in the MMA subsystem.
- Samples the five requesters' command-valid lines and grants one of them.
- Snoops the multiplexed master-side handshakes and holds the grant until the whole transaction completes: command, all write beats, and all responses.
- Drives `sel` = 7 (no requester selected; the mux forces all master-side valids to 0) whenever no grant is active.

Parameters:
- N_REQ, 5, number of requesters; fixed at 5 (sel encodes 0..4; 7 = none).
- LEN_W, 8, width of the ICB ext burst-length field. Beats = len+1.
- TIMEOUT_CYC, 1024, watchdog limit in cycles per granted transaction; 0 disables the watchdog.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_vld  in  5  cmd.valid of requester i (raw, before the mux)
- m_cmd_valid  in  1  master-side cmd valid (mux output)
- m_cmd_ready  in  1  master-side cmd ready
- m_cmd_read  in  1  master-side cmd read flag
- m_cmd_len  in  LEN_W  master-side cmd burst length
- m_w_valid  in  1  master-side write-data valid
- m_w_ready  in  1  master-side write-data ready
- m_rsp_valid  in  1  master-side response valid
- m_rsp_ready  in  1  master-side response ready
- sel  out  3  registered mux select: 0..4 = granted requester, 7 = none
- busy  out  1  1 while any grant is held
- timeout_err  out  1  one-cycle pulse when the watchdog releases a stuck grant

Behaviour:
- Reset (rst=1 at a clock edge):
  - sel=7, busy=0, timeout_err=0.
  - Round-robin pointer `last` = 4, so requester 0 has the highest priority first.
  - All counters = 0; state = IDLE.
  - Reset mid-transaction abandons the transaction immediately. No pulse on timeout_err.
- Handshake definitions:
  - cmd_hs = m_cmd_valid & m_cmd_ready
  - w_hs = m_w_valid & m_w_ready
  - r_hs = m_rsp_valid & m_rsp_ready
- IDLE:
  - sel=7, busy=0.
  - If req_vld!=0, pick the first set bit searching (last+1) mod 5 upward with wrap-around.
  - Register sel=winner, set busy=1, go to CMD.
  - Grant latency: req_vld high at edge k gives sel valid after edge k; cmd_hs is possible in cycle k+1 at the earliest.
- CMD:
  - Wait for cmd_hs. On cmd_hs, latch beats = m_cmd_len+1 (LEN_W+1 bits, no overflow) and latch the read flag.
  - Read: go to RRSP with rsp_cnt=0.
  - Write: go to WDAT with w_cnt=0.
  - If w_hs occurs in the same cycle as cmd_hs on a write, count it: w_cnt=1. If beats==1, go straight to WRSP.
  - If the granted requester drops its req before cmd_hs, go back to IDLE, sel=7. `last` is not updated.
- WDAT:
  - Each w_hs increments w_cnt.
  - When w_cnt reaches beats, go to WRSP.
  - A write expects exactly one response.
- WRSP: first r_hs completes the transaction.
- RRSP:
  - Each r_hs increments rsp_cnt.
  - When rsp_cnt reaches beats, the transaction completes.
- Completion:
  - In the completing cycle, sel is still the granted ID, so the response routes correctly.
  - Next edge: last=granted ID, sel=7, busy=0, state=IDLE.
  - There is one mandatory IDLE cycle between grants; back-to-back grants to the same requester are allowed only via round-robin.
- sel never changes while busy=1 except on completion, timeout, or the req-drop abort in CMD.
- Handshakes that occur while in IDLE are ignored.
- Write-data and response handshakes that arrive before cmd_hs are ignored.
- Watchdog:
  - cyc_cnt clears on every grant and counts every busy cycle.
  - If TIMEOUT_CYC!=0 and cyc_cnt==TIMEOUT_CYC-1 without completion: pulse timeout_err for 1 cycle, force IDLE, sel=7, last=granted ID.
  - If completion and timeout fall in the same cycle, completion wins and there is no pulse.
- Requesters not granted see cmd_ready=0 through the mux. The arbiter does not gate req_vld.

Test Plan:
- Single read: reset, req_vld=5'b00100, len=3 with rsp_ready=1 → sel=2 one cycle after req; 4 r_hs observed; sel=7 the cycle after the 4th; busy drops.
- Round-robin fairness: req_vld=5'b11111 held, every transaction a len=0 read → grant order 0,1,2,3,4,0 with exactly one IDLE cycle between grants.
- Write burst: len=2, cmd_hs coincident with the first w_hs, wready toggling 1/0 → WRSP entered after the 3rd w_hs; release only after 1 r_hs; earlier rsp_valid while in WDAT is not counted.
- Abort: grant requester 1, drop req_vld[1] before cmd_ready → sel=7 next cycle; `last` unchanged, so a new req from 1 and 3 grants 1 again.
- Watchdog: TIMEOUT_CYC=16, read granted, response never returned → timeout_err pulses on busy cycle 16; sel=7; the next grant goes to the next requester.
- Reset mid-burst: assert rst during RRSP → sel=7, busy=0 next cycle, no timeout_err; the first grant after reset goes to requester 0.
